// File: rtl/uart_tx_arbiter.sv
// Purpose: buffers bytes from three prioritised clients into one FIFO and paces them into uart_tx.
// Latency: a byte written at edge N strobes uart_wr at edge N+1 when the FIFO was empty, the FSM is idle and uart_ready is high.
// Backpressure: client ready drops while the FIFO is full; the drain waits for uart_ready after a GUARD-cycle blanking window.
// Option: define UART_TX_ARB_CRLF_EN to expand each LF (8'h0A) into a CR,LF strobe pair.
module uart_tx_arbiter #(
  parameter int DEPTH = 16,
  parameter int GUARD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     res_wr,
  input  logic [7:0]               res_din,
  output logic                     res_ready,
  input  logic                     recv_wr,
  input  logic [7:0]               recv_din,
  output logic                     recv_ready,
  input  logic                     brd_wr,
  input  logic [7:0]               brd_din,
  output logic                     brd_ready,
  output logic                     uart_wr,
  output logic [7:0]               uart_din,
  input  logic                     uart_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_GUARD} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  state_t        state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic          uart_wr_q, uart_wr_d;
  logic [7:0]    uart_din_q, uart_din_d;
  logic          push, pop, fire, send_cr;
  logic [7:0]    push_dat, head;

  // Pointer MSB distinguishes a full buffer from an empty one.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign level = wptr_q - rptr_q;

  // Higher-priority writers mask lower ones so at most one byte lands per cycle.
  assign res_ready  = !full;
  assign recv_ready = !full && !res_wr;
  assign brd_ready  = !full && !res_wr && !recv_wr;

  // Select the single accepted client byte; readies are already mutually exclusive.
  always_comb begin
    push     = 1'b0;
    push_dat = 8'h00;
    if (res_wr && res_ready) begin
      push     = 1'b1;
      push_dat = res_din;
    end else if (recv_wr && recv_ready) begin
      push     = 1'b1;
      push_dat = recv_din;
    end else if (brd_wr && brd_ready) begin
      push     = 1'b1;
      push_dat = brd_din;
    end
  end

  assign wptr_d = push ? (wptr_q + PW'(1)) : wptr_q;
  assign rptr_d = pop  ? (rptr_q + PW'(1)) : rptr_q;
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign fire   = (state_q == ST_IDLE) && !empty && uart_ready;

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= push_dat;
    end
  end

`ifdef UART_TX_ARB_CRLF_EN
  logic cr_sent_q, cr_sent_d;

  // An LF at the head first goes out as CR without popping; the flag remembers that.
  assign send_cr = (head == 8'h0A) && !cr_sent_q;

  // Track whether the CR for the current head LF has been issued.
  always_comb begin
    cr_sent_d = cr_sent_q;
    if (fire) begin
      cr_sent_d = send_cr;
    end
  end

  // CR-issued flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`else
  assign send_cr = 1'b0;
`endif

  // Drain FSM: one strobe per uart_ready, then blank uart_ready for GUARD cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    uart_wr_d  = 1'b0;
    uart_din_d = uart_din_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          uart_wr_d = 1'b1;
          cnt_d     = GW'(GUARD);
          state_d   = ST_GUARD;
          if (send_cr) begin
            uart_din_d = 8'h0D;
          end else begin
            uart_din_d = head;
            pop        = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        cnt_d = cnt_q - GW'(1);
        if (cnt_q <= GW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      uart_wr_q  <= 1'b0;
      uart_din_q <= 8'h00;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      uart_wr_q  <= uart_wr_d;
      uart_din_q <= uart_din_d;
    end
  end

  assign uart_wr  = uart_wr_q;
  assign uart_din = uart_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of accepted bytes checked against every uart_wr strobe.
// Clients are driven after the rising edge; DUT outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;
  localparam int DEPTH = 16;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       res_wr = 1'b0, recv_wr = 1'b0, brd_wr = 1'b0;
  logic [7:0] res_din = 8'h00, recv_din = 8'h00, brd_din = 8'h00;
  logic       res_ready, recv_ready, brd_ready;
  logic       uart_wr;
  logic [7:0] uart_din;
  logic       uart_ready = 1'b1;
  logic [$clog2(DEPTH):0] level;
  logic       empty, full;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset),
    .res_wr(res_wr), .res_din(res_din), .res_ready(res_ready),
    .recv_wr(recv_wr), .recv_din(recv_din), .recv_ready(recv_ready),
    .brd_wr(brd_wr), .brd_din(brd_din), .brd_ready(brd_ready),
    .uart_wr(uart_wr), .uart_din(uart_din), .uart_ready(uart_ready),
    .level(level), .empty(empty), .full(full)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sbq [$];
  int         n_pushed = 0;
  int         n_strobes = 0;
  int         mode = 0;      // 0: uart always ready, 1: held busy, 2: uart_tx model
  bit         gap_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobes for one accepted byte.
  task automatic sb_push(input logic [7:0] b);
`ifdef UART_TX_ARB_CRLF_EN
    if (b == 8'h0A) begin
      sbq.push_back(8'h0D);
      n_pushed++;
    end
`endif
    sbq.push_back(b);
    n_pushed++;
  endtask

  task automatic drive(input int c, input logic w, input logic [7:0] b);
    case (c)
      0: begin res_wr = w;  res_din = b;  end
      1: begin recv_wr = w; recv_din = b; end
      default: begin brd_wr = w; brd_din = b; end
    endcase
  endtask

  function automatic logic rdy_of(input int c);
    case (c)
      0: return res_ready;
      1: return recv_ready;
      default: return brd_ready;
    endcase
  endfunction

  // Hold wr/din until ready is seen, then drop after the accepting edge.
  task automatic send(input int c, input logic [7:0] b);
    bit got;
    got = 1'b0;
    drive(c, 1'b1, b);
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (rdy_of(c) === 1'b1) got = 1'b1;
    end
    if (got) begin
      sb_push(b);
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 32'd0, 32'd1);
    end
    drive(c, 1'b0, 8'h00);
  endtask

  task automatic wait_drain(input int limit);
    for (int k = 0; k < limit && (sbq.size() != 0 || empty !== 1'b1); k++) begin
      @(negedge clk);
    end
    repeat (GUARD + 3) @(negedge clk);
    chk("drain_queue", sbq.size(), 32'd0);
    chk("drain_level", level, 32'd0);
  endtask

  // uart_tx model: ready drops one cycle after a strobe and stays low 20 cycles.
  int busy = 0;
  bit prev_wr_m = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mode == 2) begin
      if (busy > 0) busy--;
      if (prev_wr_m) busy = 20;
      prev_wr_m  = (uart_wr === 1'b1);
      uart_ready = (busy == 0);
    end else begin
      busy       = 0;
      prev_wr_m  = 1'b0;
      uart_ready = (mode == 0);
    end
  end

  // Monitor: every strobe must match the scoreboard head.
  int         cyc = 0, last_cyc = 0;
  bit         had_prev = 1'b0, mon_prev = 1'b0;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    cyc++;
    if (uart_wr === 1'b1) begin
      n_strobes++;
      chk("no_back_to_back", mon_prev, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'(uart_din), 32'hFFFF_FFFF);
      end else begin
        exp_b = sbq.pop_front();
        chk("uart_din", 32'(uart_din), 32'(exp_b));
      end
      if (gap_chk && had_prev) chk("strobe_gap_ge21", 32'((cyc - last_cyc) >= 21), 32'd1);
      had_prev = 1'b1;
      last_cyc = cyc;
    end
    if (!gap_chk) had_prev = 1'b0;
    mon_prev = (uart_wr === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0;
    // Reset held with every client writing: nothing may be enqueued.
    drive(0, 1'b1, 8'h11);
    drive(1, 1'b1, 8'h22);
    drive(2, 1'b1, 8'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_wr", uart_wr, 32'd0);
    chk("rst_uart_din", uart_din, 32'h00);
    chk("rst_level", level, 32'd0);
    chk("rst_empty", empty, 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_res_ready", res_ready, 32'd1);
    chk("post_rst_full", full, 32'd0);
    chk("post_rst_level", level, 32'd0);
    repeat (4) @(negedge clk);
    chk("post_rst_no_strobe", n_strobes, 32'd0);

    // Single byte: strobe one cycle after the write edge, exactly one cycle wide.
    @(posedge clk);
    #1;
    send(2, 8'h41);
    @(negedge clk);
    chk("single_pre_wr", uart_wr, 32'd0);
    chk("single_level1", level, 32'd1);
    @(negedge clk);
    chk("single_wr", uart_wr, 32'd1);
    chk("single_din", uart_din, 32'h41);
    @(negedge clk);
    chk("single_wr_drop", uart_wr, 32'd0);
    chk("single_level0", level, 32'd0);
    chk("single_din_hold", uart_din, 32'h41);
    wait_drain(200);

    // Collision: all three clients in the same cycle.
    @(posedge clk);
    #1;
    fork
      send(0, 8'h52);
      send(1, 8'h31);
      send(2, 8'h2E);
      begin
        @(negedge clk);
        chk("coll_res_ready", res_ready, 32'd1);
        chk("coll_recv_ready", recv_ready, 32'd0);
        chk("coll_brd_ready", brd_ready, 32'd0);
      end
    join
    wait_drain(300);

    // Full / back-pressure with uart_tx held busy.
    mode = 1;
    repeat (2) @(posedge clk);
    #2;
    s0 = n_strobes;
    p0 = n_pushed;
    for (int i = 0; i < 16; i++) send(2, 8'(i));
    @(negedge clk);
    chk("full_flag", full, 32'd1);
    chk("full_level", level, 32'd16);
    chk("full_brd_ready", brd_ready, 32'd0);
    chk("full_res_ready", res_ready, 32'd0);
    fork
      send(2, 8'h10);
      begin
        repeat (4) @(negedge clk);
        chk("full_held_brd_ready", brd_ready, 32'd0);
        chk("full_held_no_strobe", n_strobes - s0, 32'd0);
        mode = 0;
      end
    join
    wait_drain(1000);
    chk("full_strobe_count", n_strobes - s0, n_pushed - p0);

    // Pointer wrap against the uart_tx model, with strobe spacing checked.
    mode = 2;
    gap_chk = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    s0 = n_strobes;
    p0 = n_pushed;
    for (int i = 0; i < 40; i++) send(1, 8'(i * 7 + 3));
    wait_drain(3000);
    gap_chk = 1'b0;
    chk("wrap_strobe_count", n_strobes - s0, n_pushed - p0);
    chk("wrap_pushed", n_pushed - p0, 32'd40);

    // LF handling.
    mode = 0;
    repeat (30) @(posedge clk);
    #2;
    s0 = n_strobes;
    send(2, 8'h41);
    send(2, 8'h0A);
    send(2, 8'h42);
    wait_drain(300);
`ifdef UART_TX_ARB_CRLF_EN
    chk("lf_strobe_count", n_strobes - s0, 32'd4);
`else
    chk("lf_strobe_count", n_strobes - s0, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
